// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants for the bit-serial adder controller: FSM state codes and default width.
`timescale 1ns/10ps
package serial_add_ctrl_pkg;

  localparam int unsigned SA_DEFAULT_N = 8;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

endpackage

// File: rtl/serial_add_ctrl_fa_v1.sv
// One-bit full-adder cell reused by the serial adder controller.
`timescale 1ns/10ps
module fa_v1 (
  output logic sum,
  output logic carry,
  input  logic a,
  input  logic b,
  input  logic c_in
);

  assign sum   = a ^ b ^ c_in;
  assign carry = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell sequenced over N cycles, LSB first.
`timescale 1ns/10ps
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned N = SA_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         c_out
);

  localparam int unsigned CW = $clog2(N + 1);

  logic [1:0]    state;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-1:0]  sum_sr;
  logic [N-1:0]  sum_nxt;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          fa_s;
  logic          fa_c;
  logic          last_bit;

  fa_v1 u_fa (
    .sum   (fa_s),
    .carry (fa_c),
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c_in  (carry)
  );

  // Incoming sum bit enters at the MSB; the shift also covers N=1 without a special case.
  assign sum_nxt  = N'({fa_s, sum_sr} >> 1);
  assign last_bit = (cnt == CW'(N - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State sequencing IDLE -> RUN (N cycles) -> DONE (one cycle) -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (last_bit) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture, per-bit shifting, carry tracking and result update on RUN exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      c_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= c_in;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum_sr <= sum_nxt;
          carry  <= fa_c;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            sum   <= sum_nxt;
            c_out <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at N=8 and N=1 against an arithmetic reference.
`timescale 1ns/10ps
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, c_out8;
  logic [7:0] sum8;

  logic       start1 = 1'b0;
  logic       a1 = 1'b0;
  logic       b1 = 1'b0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, c_out1;
  logic       sum1;

  int checks = 0;
  int errors = 0;

  logic [8:0] q8[$];
  logic [8:0] q1[$];
  int         ph8 = -1;
  int         ph1 = -1;
  logic [8:0] last8 = '0;
  logic [8:0] last1 = '0;

  serial_add_ctrl #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(c_out8)
  );

  serial_add_ctrl #(.N(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c_in(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(c_out1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, N=8: tracks edges since acceptance and issues expected results.
  always @(negedge clk) begin
    if (rst) begin
      ph8 = -1;
      q8.delete();
      chk("rst_busy8", 9'(busy8), 9'(0));
      chk("rst_done8", 9'(done8), 9'(0));
    end else begin
      chk("busy8", 9'(busy8), 9'(ph8 >= 0 && ph8 < 8));
      chk("done8", 9'(done8), 9'(ph8 == 8));
      if (ph8 == -1) begin
        if (start8) begin
          q8.push_back(9'(a8) + 9'(b8) + 9'(cin8));
          ph8 = 0;
        end
      end else if (ph8 == 8) begin
        ph8 = -1;
      end else begin
        ph8++;
      end
    end
  end

  // Monitor, N=8: pops the scoreboard on done, otherwise requires the result to hold.
  always @(negedge clk) begin
    if (rst) begin
      last8 = '0;
      chk("rst_result8", 9'({c_out8, sum8}), 9'(0));
    end else if (done8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result8: done with empty scoreboard, got 0x%0h expected none", {c_out8, sum8});
      end else begin
        last8 = q8.pop_front();
        chk("result8", 9'({c_out8, sum8}), last8);
      end
    end else begin
      chk("hold8", 9'({c_out8, sum8}), last8);
    end
  end

  // Reference model, N=1.
  always @(negedge clk) begin
    if (rst) begin
      ph1 = -1;
      q1.delete();
      chk("rst_busy1", 9'(busy1), 9'(0));
      chk("rst_done1", 9'(done1), 9'(0));
    end else begin
      chk("busy1", 9'(busy1), 9'(ph1 == 0));
      chk("done1", 9'(done1), 9'(ph1 == 1));
      if (ph1 == -1) begin
        if (start1) begin
          q1.push_back(9'(a1) + 9'(b1) + 9'(cin1));
          ph1 = 0;
        end
      end else if (ph1 == 1) begin
        ph1 = -1;
      end else begin
        ph1++;
      end
    end
  end

  // Monitor, N=1.
  always @(negedge clk) begin
    if (rst) begin
      last1 = '0;
      chk("rst_result1", 9'({c_out1, sum1}), 9'(0));
    end else if (done1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result1: done with empty scoreboard, got 0x%0h expected none", {c_out1, sum1});
      end else begin
        last1 = q1.pop_front();
        chk("result1", 9'({c_out1, sum1}), last1);
      end
    end else begin
      chk("hold1", 9'({c_out1, sum1}), last1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    a8 = av; b8 = bv; cin8 = cv;
    start8 = 1'b1;
    step(1);
    start8 = 1'b0;
    step(10);
  endtask

  initial begin
    step(3);
    rst = 1'b0;

    op8(8'h00, 8'h00, 1'b0);
    op8(8'hFF, 8'h01, 1'b0);
    op8(8'h5A, 8'h25, 1'b1);

    // Inputs scrambled and start pulsed while RUN and DONE.
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    start8 = 1'b1;
    step(1);
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start8 = 1'b0;
    step(3);
    start8 = 1'b1;
    step(1);
    start8 = 1'b0;
    step(4);
    start8 = 1'b1;
    step(1);
    start8 = 1'b0;
    step(3);

    // Back-to-back operation with start held high.
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    start8 = 1'b1;
    step(35);
    start8 = 1'b0;
    step(12);

    // Asynchronous reset after four bits of a run.
    a8 = 8'hC3; b8 = 8'h7E; cin8 = 1'b1;
    start8 = 1'b1;
    step(1);
    start8 = 1'b0;
    step(4);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    op8(8'h81, 8'h7F, 1'b1);

    // N=1 truth table.
    for (int i = 0; i < 8; i++) begin
      a1 = i[2]; b1 = i[1]; cin1 = i[0];
      start1 = 1'b1;
      step(1);
      start1 = 1'b0;
      step(3);
    end

    // Random traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      start8 = ($urandom_range(0, 2) == 0);
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      cin8   = 1'($urandom);
      start1 = ($urandom_range(0, 2) == 0);
      a1     = 1'($urandom);
      b1     = 1'($urandom);
      cin1   = 1'($urandom);
      step(1);
    end
    start8 = 1'b0;
    start1 = 1'b0;
    step(15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
